// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: data width and ALU operation codes
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRA  = 4'd1;
  localparam logic [3:0] ALU_SRL  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_XOR  = 4'd9;
  localparam logic [3:0] ALU_NOR  = 4'd10;
  localparam logic [3:0] ALU_SLT  = 4'd11;
  localparam logic [3:0] ALU_SLTU = 4'd12;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - purely combinational ALU datapath with signed-overflow detect
module alu_core
  import cpu_pkg::*;
(
  input  logic [3:0]      i_aluop,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result,
  output logic            o_ovf
);

  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_diff;
  logic            w_add_ovf;
  logic            w_sub_ovf;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  // Subtraction overflows when the operands' signs differ, i.e. A and ~B agree.
  assign w_add_ovf = (i_a[XLEN-1] == i_b[XLEN-1]) && (w_sum[XLEN-1]  != i_a[XLEN-1]);
  assign w_sub_ovf = (i_a[XLEN-1] != i_b[XLEN-1]) && (w_diff[XLEN-1] != i_a[XLEN-1]);

  always_comb begin
    o_result = '0;
    o_ovf    = 1'b0;
    case (i_aluop)
      ALU_SLL:  o_result = i_b << i_a[4:0];
      ALU_SRA:  o_result = $unsigned($signed(i_b) >>> i_a[4:0]);
      ALU_SRL:  o_result = i_b >> i_a[4:0];
      ALU_ADD: begin
        o_result = w_sum;
        o_ovf    = w_add_ovf;
      end
      ALU_SUB: begin
        o_result = w_diff;
        o_ovf    = w_sub_ovf;
      end
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_NOR:  o_result = ~(i_a | i_b);
      ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      default: begin
        o_result = '0;
        o_ovf    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute stage: valid/ready handshake around one output register
module alu_exec_stage
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_aluop,
  input  logic [XLEN-1:0] in_src_a,
  input  logic [XLEN-1:0] in_src_b,
  input  logic            in_ovf_en,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_ovf,
  output logic [4:0]      out_rd,
  output logic            out_wen
);

  logic [XLEN-1:0] w_result;
  logic            w_core_ovf;
  logic            w_trap;
  logic            w_accept;

  logic            r_valid;
  logic [XLEN-1:0] r_result;
  logic            r_ovf;
  logic [4:0]      r_rd;
  logic            r_wen;

  alu_core u_alu_core (
    .i_aluop  (in_aluop),
    .i_a      (in_src_a),
    .i_b      (in_src_b),
    .o_result (w_result),
    .o_ovf    (w_core_ovf)
  );

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_trap   = in_ovf_en && w_core_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_rd     <= '0;
      r_wen    <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_wen   <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_result <= w_result;
      r_ovf    <= w_trap;
      r_rd     <= in_rd;
      r_wen    <= in_wen && !w_trap;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid  = r_valid;
  assign out_result = r_result;
  assign out_zero   = (r_result == '0);
  assign out_ovf    = r_ovf;
  assign out_rd     = r_rd;
  assign out_wen    = r_wen;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed self-checking bench for alu_exec_stage
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_aluop;
  logic [31:0] in_src_a;
  logic [31:0] in_src_b;
  logic        in_ovf_en;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_ovf;
  logic [4:0]  out_rd;
  logic        out_wen;

  int n_checks = 0;
  int n_pass   = 0;

  alu_exec_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_aluop   (in_aluop),
    .in_src_a   (in_src_a),
    .in_src_b   (in_src_b),
    .in_ovf_en  (in_ovf_en),
    .in_rd      (in_rd),
    .in_wen     (in_wen),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf),
    .out_rd     (out_rd),
    .out_wen    (out_wen)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic en, input logic [4:0] rd, input logic wen);
    in_aluop  = op;
    in_src_a  = a;
    in_src_b = b;
    in_ovf_en = en;
    in_rd     = rd;
    in_wen    = wen;
  endtask

  // Presents one op with in_valid held high and checks it one edge later.
  task automatic run_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic en, input logic [31:0] exp_res,
                         input logic exp_ovf, input logic exp_wen, input logic exp_zero);
    drive(op, a, b, en, 5'd9, 1'b1);
    in_valid = 1'b1;
    step();
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_res"}, out_result, exp_res);
    check({tag, "_ovf"}, {31'b0, out_ovf}, {31'b0, exp_ovf});
    check({tag, "_wen"}, {31'b0, out_wen}, {31'b0, exp_wen});
    check({tag, "_zero"}, {31'b0, out_zero}, {31'b0, exp_zero});
    check({tag, "_rd"}, {27'b0, out_rd}, 32'd9);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    drive(4'd5, 32'd1, 32'd2, 1'b0, 5'd4, 1'b1);
    #3;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_zero", {31'b0, out_zero}, 32'd1);
    check("rst_ovf", {31'b0, out_ovf}, 32'd0);
    check("rst_rd", {27'b0, out_rd}, 32'd0);
    check("rst_wen", {31'b0, out_wen}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("rst_no_accept", {31'b0, out_valid}, 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;

    // Back-to-back stream, out_ready held high.
    run_vec("add_ovf",   4'd5,  32'h7FFFFFFF, 32'h1, 1'b1, 32'h80000000, 1'b1, 1'b0, 1'b0);
    run_vec("add_noen",  4'd5,  32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    run_vec("sll",       4'd0,  32'd4, 32'h80000010, 1'b0, 32'h00000100, 1'b0, 1'b1, 1'b0);
    run_vec("sra",       4'd1,  32'd4, 32'h80000010, 1'b0, 32'hF8000001, 1'b0, 1'b1, 1'b0);
    run_vec("srl",       4'd2,  32'd4, 32'h80000010, 1'b0, 32'h08000001, 1'b0, 1'b1, 1'b0);
    run_vec("slt",       4'd11, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h1, 1'b0, 1'b1, 1'b0);
    run_vec("sltu",      4'd12, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    run_vec("sub_zero",  4'd6,  32'd5, 32'd5, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
    run_vec("sub_ovf",   4'd6,  32'h80000000, 32'h1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0);
    run_vec("and",       4'd7,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 1'b0, 1'b1, 1'b0);
    run_vec("or",        4'd8,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hFFF0FFF0, 1'b0, 1'b1, 1'b0);
    run_vec("xor",       4'd9,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0FF00FF0, 1'b0, 1'b1, 1'b0);
    run_vec("nor",       4'd10, 32'h0F0F0000, 32'h00FF00FF, 1'b0, 32'hF000FF00, 1'b0, 1'b1, 1'b0);
    run_vec("undef3",    4'd3,  32'h12345678, 32'h9ABCDEF0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
    run_vec("undef13",   4'd13, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    step();
    check("drain_valid", {31'b0, out_valid}, 32'd0);

    // Stall: hold the first result while a second op waits.
    drive(4'd5, 32'd1, 32'd2, 1'b0, 5'd3, 1'b1);
    in_valid = 1'b1;
    step();
    out_ready = 1'b0;
    drive(4'd8, 32'h10, 32'h01, 1'b0, 5'd7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      check("stall_result", out_result, 32'd3);
      check("stall_rd", {27'b0, out_rd}, 32'd3);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("unstall_result", out_result, 32'h11);
    check("unstall_rd", {27'b0, out_rd}, 32'd7);
    check("unstall_valid", {31'b0, out_valid}, 32'd1);

    // Flush dominates a same-cycle accept.
    drive(4'd5, 32'h7FFFFFFF, 32'h1, 1'b1, 5'd2, 1'b1);
    flush = 1'b1;
    step();
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_wen", {31'b0, out_wen}, 32'd0);
    check("flush_ovf", {31'b0, out_ovf}, 32'd0);
    flush = 1'b0;

    // Reset between edges while stalled drops the held result.
    drive(4'd8, 32'h5, 32'h0, 1'b0, 5'd6, 1'b1);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    check("pre_rst_result", out_result, 32'h5);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_zero", {31'b0, out_zero}, 32'd1);
    check("midrst_result", out_result, 32'd0);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    check("post_rst_valid", {31'b0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
